// File: rtl/maxpool_ser_win_if.sv
// Bus bundle for maxpool_ser_win.
//   master : upstream producer side (drives slices, receives pooled results)
//   slave  : the pooling block itself
// Signals:
//   vld_in   slice valid, shared by all channels
//   last_in  frame end, meaningful only with the final slice of a word
//   data_in  [NO_CH-1:0][SER_BW-1:0] per-channel slices, LS slice first
//   vld_out  one-cycle result strobe
//   last_out window was closed early by last_in (qualified by vld_out)
//   data_out [NO_CH-1:0][BW_IN-1:0] per-channel pooled maxima
interface maxpool_ser_win_if #(
  parameter int NO_CH  = 10,
  parameter int BW_IN  = 12,
  parameter int SER_BW = 4
);
  logic                           vld_in;
  logic                           last_in;
  logic [NO_CH-1:0][SER_BW-1:0]   data_in;
  logic                           vld_out;
  logic                           last_out;
  logic [NO_CH-1:0][BW_IN-1:0]    data_out;

  modport master (
    output vld_in, last_in, data_in,
    input  vld_out, last_out, data_out
  );

  modport slave (
    input  vld_in, last_in, data_in,
    output vld_out, last_out, data_out
  );
endinterface

// File: rtl/maxpool_ser_win.sv
// Per-channel 1D max-pool over a window of POOL_K words, fed bit-serially.
// Stage 1 deserialises SER_BW-wide slices (LS slice first) into full words and
// decides per word whether it opens and/or closes a window. Stage 2 keeps a
// running maximum per channel and emits it when the window closes.
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset; discards any partial word/window
//   pool  slave side of maxpool_ser_win_if (vld_in/last_in/data_in in,
//         vld_out/last_out/data_out out)
module maxpool_ser_win #(
  parameter int NO_CH  = 10,
  parameter int BW_IN  = 12,
  parameter int SER_BW = 4,
  parameter int POOL_K = 2,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  maxpool_ser_win_if.slave pool
);

  localparam int NSLICE = BW_IN / SER_BW;
  localparam int SCW    = $clog2(NSLICE) + 1;
  localparam int WCW    = $clog2(POOL_K) + 1;

  typedef logic [NO_CH-1:0][BW_IN-1:0] word_vec_t;

  // Stage 1 state
  logic [SCW-1:0] slice_cnt;
  logic [WCW-1:0] word_cnt;
  word_vec_t      word_nxt;
  word_vec_t      word_q;
  logic           word_vld;
  logic           word_first;
  logic           word_close;
  logic           word_last;
  logic           final_slice;

  // Stage 2 state
  word_vec_t      run_max;
  word_vec_t      cand;
  word_vec_t      data_q;
  logic           vld_q;
  logic           last_q;

  function automatic logic gt(input logic [BW_IN-1:0] a, input logic [BW_IN-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  assign final_slice = pool.vld_in && (slice_cnt == SCW'(NSLICE - 1));

  // The shift register only holds the slices preceding the final one; the
  // complete word is that history with the current slice on top.
  generate
    if (NSLICE == 1) begin : g_single
      always_comb begin
        word_nxt = pool.data_in;
      end
    end else begin : g_multi
      localparam int SH = BW_IN - SER_BW;
      logic [NO_CH-1:0][SH-1:0] sr_q;

      always_comb begin
        word_nxt = '0;
        for (int unsigned ch = 0; ch < NO_CH; ch++)
          word_nxt[ch] = {pool.data_in[ch], sr_q[ch]};
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sr_q <= '0;
        end else if (pool.vld_in) begin
          for (int unsigned ch = 0; ch < NO_CH; ch++)
            sr_q[ch] <= word_nxt[ch][BW_IN-1:SER_BW];
        end
      end
    end
  endgenerate

  // Stage 1: slice/word counting, word capture and window framing flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      slice_cnt  <= '0;
      word_cnt   <= '0;
      word_q     <= '0;
      word_vld   <= 1'b0;
      word_first <= 1'b0;
      word_close <= 1'b0;
      word_last  <= 1'b0;
    end else begin
      word_vld <= final_slice;
      if (pool.vld_in) begin
        if (final_slice) begin
          slice_cnt  <= '0;
          word_q     <= word_nxt;
          word_first <= (word_cnt == '0);
          word_close <= (word_cnt == WCW'(POOL_K - 1)) || pool.last_in;
          word_last  <= pool.last_in;
          if ((word_cnt == WCW'(POOL_K - 1)) || pool.last_in)
            word_cnt <= '0;
          else
            word_cnt <= word_cnt + WCW'(1);
        end else begin
          slice_cnt <= slice_cnt + SCW'(1);
        end
      end
    end
  end

  // First word of a window replaces the running max instead of comparing.
  always_comb begin
    cand = '0;
    for (int unsigned ch = 0; ch < NO_CH; ch++) begin
      if (word_first || gt(word_q[ch], run_max[ch]))
        cand[ch] = word_q[ch];
      else
        cand[ch] = run_max[ch];
    end
  end

  // Stage 2: running max update or window close.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_max <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      vld_q <= word_vld && word_close;
      if (word_vld) begin
        if (word_close) begin
          data_q <= cand;
          last_q <= word_last;
        end else begin
          run_max <= cand;
        end
      end
    end
  end

  assign pool.vld_out  = vld_q;
  assign pool.last_out = last_q;
  assign pool.data_out = data_q;

endmodule
